hazard_stall_ctrl: RTL
======================

// Module: hazard_stall_ctrl
// PURPOSE
//   ID-stage hazard/stall controller. Drives the NoOP_i input of the main control decoder,
//   together with the PC and IF/ID write enables and the IF/ID flush.
//   - Keeps a registered shadow of the instruction in EX, so it detects load-use hazards internally.
//   - Applies flush on a taken branch.
//   - On ecall: drains the pipeline, then holds the core halted until reset.
// PARAMETERS
//   DRAIN_CYCLES  3   bubble cycles after ecall before Halted_o rises (>=1)
//   CNT_W         16  width of the load-use stall performance counter
// PORTS
//   clk_i           in   1      single clock, all state on rising edge
//   rst_i           in   1      reset: synchronous, active-high
//   id_opcode_i     in   7      opcode of instruction in ID
//   id_rs1_i        in   5      rs1 field of instruction in ID
//   id_rs2_i        in   5      rs2 field of instruction in ID
//   id_rd_i         in   5      rd field of instruction in ID
//   branch_taken_i  in   1      ID-stage branch comparator result (beq/bne taken)
//   NoOP_o          out  1      1 = control decoder emits bubble into ID/EX
//   PCWrite_o       out  1      1 = PC may update
//   IFIDWrite_o     out  1      1 = IF/ID register may load
//   Flush_o         out  1      1 = IF/ID register cleared to nop (0x00000013 not required; all-zero)
//   Halted_o        out  1      1 = program ended; sticky until reset
//   stall_count_o   out  CNT_W  number of load-use stall cycles since reset, saturating
// BEHAVIOUR
//   State: ex_load_q (EX holds lw), ex_rd_q[4:0], fsm {RUN, DRAIN, HALT}, drain_cnt, stall_cnt.
//   Reset (rst_i=1 at edge): fsm=RUN, ex_load_q=0, ex_rd_q=0, drain_cnt=0, stall_cnt=0.
//     While rst_i=1, outputs are forced: NoOP_o=1, PCWrite_o=0, IFIDWrite_o=0, Flush_o=0, Halted_o=0.
//     Reset mid-DRAIN or in HALT returns to RUN.
//   Register use by opcode:
//     - uses rs1: 0110011, 0010011, 0000011, 0100011, 1100011
//     - uses rs2: 0110011, 0100011, 1100011
//     - other opcodes use neither register
//   hazard = RUN & ex_load_q & ex_rd_q!=0 & ((use_rs1 & rs1==ex_rd_q) | (use_rs2 & rs2==ex_rd_q)).
//   Outputs are Mealy, combinational from state and ID inputs, with zero latency:
//     - RUN, hazard:
//       - NoOP=1, PCWrite=0, IFIDWrite=0, Flush=0.
//       - Branch is ignored; stall wins over flush.
//     - RUN, no hazard, ecall (1110011):
//       - NoOP=0, PCWrite=0, IFIDWrite=0, Flush=0.
//       - Next state DRAIN, drain_cnt=DRAIN_CYCLES-1.
//     - RUN, no hazard, opcode==1100011 & branch_taken_i:
//       - NoOP=0, PCWrite=1, IFIDWrite=1, Flush=1.
//     - RUN, otherwise: NoOP=0, PCWrite=1, IFIDWrite=1, Flush=0.
//       - branch_taken_i with a non-branch opcode is ignored.
//     - DRAIN:
//       - NoOP=1, PCWrite=0, IFIDWrite=0, Flush=0.
//       - drain_cnt decrements; at 0, next state is HALT.
//     - HALT: as DRAIN, plus Halted_o=1. ID inputs are ignored.
//   Shadow update each edge:
//     - RUN & !hazard & opcode!=ecall: ex_load_q <= (opcode==0000011), ex_rd_q <= id_rd_i.
//     - Otherwise (stall, ecall, DRAIN, HALT): ex_load_q <= 0, ex_rd_q <= 0.
//     - Consequence: a load-use stall lasts exactly 1 cycle.
//     - Consequence: back-to-back lw followed by a dependent instruction stalls once per lw.
//   stall_cnt: +1 on every hazard cycle; holds at all-ones, no wrap.
//   Halted_o: registered from fsm==HALT, so it rises exactly DRAIN_CYCLES+1 edges after the ecall cycle.
// TESTING
//   1. Reset:
//      - With rst_i=1, outputs read NoOP=1, PCWrite=0, IFIDWrite=0, Halted=0.
//      - After release with opcode=0010011, outputs read NoOP=0, PCWrite=1, IFIDWrite=1, count=0.
//   2. Load-use:
//      - Stimulus: lw rd=5, then add rs1=5, held in ID.
//      - Exactly 1 cycle NoOP=1, PCWrite=0, IFIDWrite=0; next cycle released.
//      - stall_count_o=1.
//   3. No false stall:
//      - lw rd=0 then add rs1=0: no stall.
//      - lw rd=7 then addi rs1=3 with rs2 field=7: no stall, since rs2 is unused.
//   4. Branch:
//      - beq taken with no hazard: Flush=1 for 1 cycle.
//      - lw rd=4 then beq rs2=4 taken: cycle 1 stall with Flush=0; cycle 2 Flush=1.
//   5. ecall with DRAIN_CYCLES=3:
//      - ecall cycle: PCWrite=0, NoOP=0.
//      - Next 3 cycles: NoOP=1.
//      - Halted_o=1 from the 4th edge onward; it stays 1 under any stimulus.
//   6. Reset in DRAIN and counter saturation:
//      - rst_i during DRAIN returns to RUN with Halted=0.
//      - With CNT_W=2, 5 hazards give stall_count_o=3.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard/stall controller: load-use stall, taken-branch flush,
// and ecall drain-then-halt sequencing for the control decoder and PC/IF-ID enables.
module hazard_stall_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [6:0]       id_opcode_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic             branch_taken_i,
  output logic             NoOP_o,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             Flush_o,
  output logic             Halted_o,
  output logic [CNT_W-1:0] stall_count_o
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [DW-1:0]    drain_cnt;
  logic [DW-1:0]    drain_next;
  logic             halted_q;
  logic             ex_load_q;
  logic [4:0]       ex_rd_q;
  logic [CNT_W-1:0] stall_cnt;

  logic use_rs1;
  logic use_rs2;
  logic hazard;
  logic is_ecall;
  logic take_branch;

  // Which source registers the ID instruction actually reads
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (id_opcode_i)
      OP_R, OP_STORE, OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_IMM, OP_LOAD: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
      end
      default: begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
      end
    endcase
  end

  assign hazard = (state == RUN) & ex_load_q & (ex_rd_q != 5'd0) &
                  ((use_rs1 & (id_rs1_i == ex_rd_q)) | (use_rs2 & (id_rs2_i == ex_rd_q)));
  assign is_ecall    = (id_opcode_i == OP_ECALL);
  assign take_branch = (id_opcode_i == OP_BRANCH) & branch_taken_i;

  // State register; Halted is registered from the next state so it rises with HALT
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= RUN;
      drain_cnt <= {DW{1'b0}};
      halted_q  <= 1'b0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_next;
      halted_q  <= (state_next == HALT);
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    drain_next = drain_cnt;
    case (state)
      RUN: begin
        if (!hazard && is_ecall) begin
          state_next = DRAIN;
          drain_next = DW'(DRAIN_CYCLES - 1);
        end else begin
          state_next = RUN;
        end
      end
      DRAIN: begin
        if (drain_cnt == {DW{1'b0}}) begin
          state_next = HALT;
        end else begin
          drain_next = drain_cnt - DW'(1);
        end
      end
      HALT:    state_next = HALT;
      default: state_next = RUN;
    endcase
  end

  // Output logic; reset forces a safe bubble regardless of state
  always_comb begin
    NoOP_o      = 1'b1;
    PCWrite_o   = 1'b0;
    IFIDWrite_o = 1'b0;
    Flush_o     = 1'b0;
    Halted_o    = halted_q & ~rst_i;
    if (rst_i) begin
      NoOP_o = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (hazard) begin
            NoOP_o = 1'b1;
          end else if (is_ecall) begin
            NoOP_o = 1'b0;
          end else begin
            NoOP_o      = 1'b0;
            PCWrite_o   = 1'b1;
            IFIDWrite_o = 1'b1;
            Flush_o     = take_branch;
          end
        end
        DRAIN, HALT: NoOP_o = 1'b1;
        default:     NoOP_o = 1'b1;
      endcase
    end
  end

  // EX shadow is cleared whenever no real instruction advances into EX
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_load_q <= 1'b0;
      ex_rd_q   <= 5'd0;
      stall_cnt <= {CNT_W{1'b0}};
    end else begin
      if ((state == RUN) && !hazard && !is_ecall) begin
        ex_load_q <= (id_opcode_i == OP_LOAD);
        ex_rd_q   <= id_rd_i;
      end else begin
        ex_load_q <= 1'b0;
        ex_rd_q   <= 5'd0;
      end
      if (hazard && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end else begin
        stall_cnt <= stall_cnt;
      end
    end
  end

  assign stall_count_o = stall_cnt;

endmodule
